// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions.
// hzd_state_t sequences the pipeline through normal running, halt drain and stop.
package cpu_types_pkg;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } hzd_state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int unsigned W = 32
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != {W{1'b1}})) count_d = count_q + 1'b1;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) count_q <= '0;
      else     count_q <= count_d;
   end

   assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline register sequencer: WEN/flush strobes for PC and the four stage registers,
// halt drain FSM and saturating stall/flush debug counters.
module pipeline_hazard_ctrl
   import cpu_types_pkg::*;
#(
   parameter int unsigned CNT_W = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic [4:0]       ifid_rs,
   input  logic [4:0]       ifid_rt,
   input  logic             ifid_uses_rt,
   input  logic             idex_MemRead,
   input  logic [4:0]       idex_rt,
   input  logic             exmem_MemRead,
   input  logic             exmem_MemWrite,
   input  logic             redirect,
   input  logic             exmem_halt,
   input  logic             memwb_halt,
   output logic             pc_WEN,
   output logic             ifid_WEN,
   output logic             ifid_flush,
   output logic             idex_WEN,
   output logic             idex_flush,
   output logic             exmem_WEN,
   output logic             exmem_flush,
   output logic             memwb_WEN,
   output logic             memwb_flush,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_events
);

   hzd_state_t state_q, state_d;
   logic       mem_busy, loaduse;
   logic       stall_inc, flush_inc;

   assign mem_busy = (exmem_MemRead | exmem_MemWrite) & ~dhit;
   assign loaduse  = idex_MemRead & (idex_rt != 5'd0) &
                     ((idex_rt == ifid_rs) | (ifid_uses_rt & (idex_rt == ifid_rt)));

   always_comb begin
      state_d     = state_q;
      pc_WEN      = 1'b1;
      ifid_WEN    = 1'b1;
      ifid_flush  = 1'b0;
      idex_WEN    = 1'b1;
      idex_flush  = 1'b0;
      exmem_WEN   = 1'b1;
      exmem_flush = 1'b0;
      memwb_WEN   = 1'b1;
      memwb_flush = 1'b0;
      halted      = 1'b0;
      flush_inc   = 1'b0;
      stall_inc   = 1'b0;

      if (state_q == HALTED) begin
         pc_WEN    = 1'b0;
         ifid_WEN  = 1'b0;
         idex_WEN  = 1'b0;
         exmem_WEN = 1'b0;
         memwb_WEN = 1'b0;
         halted    = 1'b1;
      end else begin
         // A frozen EX/MEM keeps redirect asserted, so it is acted on once the access completes.
         if (mem_busy) begin
            pc_WEN      = 1'b0;
            ifid_WEN    = 1'b0;
            idex_WEN    = 1'b0;
            exmem_WEN   = 1'b0;
            memwb_flush = 1'b1;
         end else if (redirect && (state_q == RUN)) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            flush_inc   = 1'b1;
         end else if (state_q == DRAIN) begin
            pc_WEN     = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
         end else if (loaduse) begin
            pc_WEN     = 1'b0;
            ifid_WEN   = 1'b0;
            idex_flush = 1'b1;
         end else if (!ihit) begin
            pc_WEN     = 1'b0;
            ifid_flush = 1'b1;
         end

         stall_inc = (state_q == RUN) && !pc_WEN;

         if (memwb_halt)                                        state_d = HALTED;
         else if ((state_q == RUN) && exmem_halt && !mem_busy)  state_d = DRAIN;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state_q <= RUN;
      else     state_q <= state_d;
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .CLK   (CLK),
      .RST   (RST),
      .inc   (stall_inc),
      .count (stall_cycles)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .CLK   (CLK),
      .RST   (RST),
      .inc   (flush_inc),
      .count (flush_events)
   );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl, built with 4-bit counters so saturation is reachable.
module tb_pipeline_hazard_ctrl;

   localparam int unsigned CW = 4;

   // {pc_WEN, ifid_WEN, ifid_flush, idex_WEN, idex_flush, exmem_WEN, exmem_flush,
   //  memwb_WEN, memwb_flush, halted}
   localparam logic [9:0] C_IDLE    = 10'b1101010100;
   localparam logic [9:0] C_LOADUSE = 10'b0001110100;
   localparam logic [9:0] C_MEMBUSY = 10'b0000000110;
   localparam logic [9:0] C_REDIR   = 10'b1111111100;
   localparam logic [9:0] C_DRAIN   = 10'b0111110100;
   localparam logic [9:0] C_NOIHIT  = 10'b0111010100;
   localparam logic [9:0] C_HALTED  = 10'b0000000001;

   logic          CLK = 1'b0;
   logic          RST;
   logic          ihit, dhit, ifid_uses_rt, idex_MemRead, exmem_MemRead, exmem_MemWrite;
   logic          redirect, exmem_halt, memwb_halt;
   logic [4:0]    ifid_rs, ifid_rt, idex_rt;
   logic          pc_WEN, ifid_WEN, ifid_flush, idex_WEN, idex_flush;
   logic          exmem_WEN, exmem_flush, memwb_WEN, memwb_flush, halted;
   logic [CW-1:0] stall_cycles, flush_events;
   logic [9:0]    ctl;

   int checks = 0;
   int errors = 0;

   assign ctl = {pc_WEN, ifid_WEN, ifid_flush, idex_WEN, idex_flush, exmem_WEN, exmem_flush,
                 memwb_WEN, memwb_flush, halted};

   always #5 CLK = ~CLK;

   pipeline_hazard_ctrl #(.CNT_W(CW)) dut (
      .CLK            (CLK),
      .RST            (RST),
      .ihit           (ihit),
      .dhit           (dhit),
      .ifid_rs        (ifid_rs),
      .ifid_rt        (ifid_rt),
      .ifid_uses_rt   (ifid_uses_rt),
      .idex_MemRead   (idex_MemRead),
      .idex_rt        (idex_rt),
      .exmem_MemRead  (exmem_MemRead),
      .exmem_MemWrite (exmem_MemWrite),
      .redirect       (redirect),
      .exmem_halt     (exmem_halt),
      .memwb_halt     (memwb_halt),
      .pc_WEN         (pc_WEN),
      .ifid_WEN       (ifid_WEN),
      .ifid_flush     (ifid_flush),
      .idex_WEN       (idex_WEN),
      .idex_flush     (idex_flush),
      .exmem_WEN      (exmem_WEN),
      .exmem_flush    (exmem_flush),
      .memwb_WEN      (memwb_WEN),
      .memwb_flush    (memwb_flush),
      .halted         (halted),
      .stall_cycles   (stall_cycles),
      .flush_events   (flush_events)
   );

   task automatic idle_inputs();
      ihit = 1'b1; dhit = 1'b1;
      ifid_rs = 5'd1; ifid_rt = 5'd2; ifid_uses_rt = 1'b0;
      idex_MemRead = 1'b0; idex_rt = 5'd0;
      exmem_MemRead = 1'b0; exmem_MemWrite = 1'b0;
      redirect = 1'b0; exmem_halt = 1'b0; memwb_halt = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge CLK);
      idle_inputs();
      RST = 1'b1;
      #2 RST = 1'b0;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      idle_inputs();
      #3;
      checks++;
      if (ctl !== C_IDLE || stall_cycles !== 4'd0 || flush_events !== 4'd0) begin
         errors++;
         $display("FAIL reset: ctl=%b stall=%0d flush=%0d, want ctl=%b stall=0 flush=0",
                  ctl, stall_cycles, flush_events, C_IDLE);
      end
      RST = 1'b0;
   endtask

   task automatic test_loaduse();
      do_reset();
      @(negedge CLK);
      idex_MemRead = 1'b1; idex_rt = 5'd8; ifid_rs = 5'd8;
      #1; checks++;
      if (ctl !== C_LOADUSE) begin
         errors++; $display("FAIL loaduse_rs: ctl=%b want %b", ctl, C_LOADUSE);
      end
      @(posedge CLK); #1; checks++;
      if (stall_cycles !== 4'd1) begin
         errors++; $display("FAIL loaduse_stall: stall=%0d want 1", stall_cycles);
      end
      @(negedge CLK);
      idex_rt = 5'd0; ifid_rs = 5'd0;
      #1; checks++;
      if (ctl !== C_IDLE) begin
         errors++; $display("FAIL loaduse_r0: ctl=%b want %b", ctl, C_IDLE);
      end
      @(negedge CLK);
      idex_rt = 5'd8; ifid_rs = 5'd3; ifid_rt = 5'd8; ifid_uses_rt = 1'b1;
      #1; checks++;
      if (ctl !== C_LOADUSE) begin
         errors++; $display("FAIL loaduse_rt: ctl=%b want %b", ctl, C_LOADUSE);
      end
      @(negedge CLK);
      ifid_uses_rt = 1'b0;
      #1; checks++;
      if (ctl !== C_IDLE) begin
         errors++; $display("FAIL loaduse_rt_unused: ctl=%b want %b", ctl, C_IDLE);
      end
      @(posedge CLK); #1; checks++;
      if (stall_cycles !== 4'd2) begin
         errors++; $display("FAIL loaduse_stall_total: stall=%0d want 2", stall_cycles);
      end
   endtask

   task automatic test_data_miss();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         exmem_MemRead = 1'b1; dhit = 1'b0; redirect = 1'b1;
         #1; checks++;
         if (ctl !== C_MEMBUSY) begin
            errors++; $display("FAIL miss_cycle%0d: ctl=%b want %b", i, ctl, C_MEMBUSY);
         end
      end
      @(negedge CLK);
      dhit = 1'b1;
      #1; checks++;
      if (ctl !== C_REDIR) begin
         errors++; $display("FAIL miss_release: ctl=%b want %b", ctl, C_REDIR);
      end
      @(posedge CLK); #1; checks++;
      if (flush_events !== 4'd1 || stall_cycles !== 4'd3) begin
         errors++;
         $display("FAIL miss_counters: flush=%0d stall=%0d want flush=1 stall=3",
                  flush_events, stall_cycles);
      end
      idle_inputs();
   endtask

   task automatic test_redirect_wins();
      do_reset();
      @(negedge CLK);
      redirect = 1'b1; ihit = 1'b0;
      idex_MemRead = 1'b1; idex_rt = 5'd9; ifid_rs = 5'd9;
      #1; checks++;
      if (ctl !== C_REDIR) begin
         errors++; $display("FAIL redirect_prio: ctl=%b want %b", ctl, C_REDIR);
      end
      @(posedge CLK); #1; checks++;
      if (stall_cycles !== 4'd0 || flush_events !== 4'd1) begin
         errors++;
         $display("FAIL redirect_counters: stall=%0d flush=%0d want stall=0 flush=1",
                  stall_cycles, flush_events);
      end
      idle_inputs();
   endtask

   task automatic test_halt();
      do_reset();
      @(negedge CLK);
      exmem_halt = 1'b1;
      #1; checks++;
      if (ctl !== C_IDLE) begin
         errors++; $display("FAIL halt_run: ctl=%b want %b", ctl, C_IDLE);
      end
      @(negedge CLK);
      exmem_halt = 1'b0; redirect = 1'b1; ihit = 1'b0;
      #1; checks++;
      if (ctl !== C_DRAIN) begin
         errors++; $display("FAIL halt_drain: ctl=%b want %b", ctl, C_DRAIN);
      end
      @(negedge CLK);
      redirect = 1'b0; memwb_halt = 1'b1;
      #1; checks++;
      if (ctl !== C_DRAIN) begin
         errors++; $display("FAIL halt_drain2: ctl=%b want %b", ctl, C_DRAIN);
      end
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         memwb_halt = 1'b0;
         ihit = 1'($urandom); dhit = 1'($urandom); redirect = 1'($urandom);
         exmem_MemRead = 1'($urandom);
         #1; checks++;
         if (ctl !== C_HALTED) begin
            errors++; $display("FAIL halted_cycle%0d: ctl=%b want %b", i, ctl, C_HALTED);
         end
      end
      checks++;
      if (stall_cycles !== 4'd0 || flush_events !== 4'd0) begin
         errors++;
         $display("FAIL halt_frozen: stall=%0d flush=%0d want 0 0", stall_cycles, flush_events);
      end
      idle_inputs();
   endtask

   task automatic test_async_reset();
      do_reset();
      repeat (5) begin
         @(negedge CLK); ihit = 1'b0;
      end
      repeat (5) begin
         @(negedge CLK); ihit = 1'b1; redirect = 1'b1;
      end
      @(negedge CLK);
      redirect = 1'b0; memwb_halt = 1'b1;
      @(negedge CLK);
      memwb_halt = 1'b0;
      #1; checks++;
      if (ctl !== C_HALTED || stall_cycles !== 4'd5 || flush_events !== 4'd5) begin
         errors++;
         $display("FAIL pre_reset: ctl=%b stall=%0d flush=%0d want %b 5 5",
                  ctl, stall_cycles, flush_events, C_HALTED);
      end
      #1 RST = 1'b1;
      #1; checks++;
      if (ctl !== C_IDLE || stall_cycles !== 4'd0 || flush_events !== 4'd0) begin
         errors++;
         $display("FAIL async_reset: ctl=%b stall=%0d flush=%0d want %b 0 0",
                  ctl, stall_cycles, flush_events, C_IDLE);
      end
      RST = 1'b0;
   endtask

   task automatic test_saturation();
      do_reset();
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK); ihit = 1'b0;
         if (i == 15) begin
            checks++;
            if (stall_cycles !== 4'd15) begin
               errors++; $display("FAIL stall_reach_max: stall=%0d want 15", stall_cycles);
            end
         end
      end
      @(negedge CLK);
      ihit = 1'b1;
      checks++;
      if (stall_cycles !== 4'd15) begin
         errors++; $display("FAIL stall_saturate: stall=%0d want 15", stall_cycles);
      end
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK); redirect = 1'b1;
      end
      @(negedge CLK);
      redirect = 1'b0;
      checks++;
      if (flush_events !== 4'd15) begin
         errors++; $display("FAIL flush_saturate: flush=%0d want 15", flush_events);
      end
   endtask

   initial begin
      test_reset();
      test_loaduse();
      test_data_miss();
      test_redirect_wins();
      test_halt();
      test_async_reset();
      test_saturation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
